// File: rtl/bsg_manycore_lock_table.sv
// Address-tagged lock table for a tile's local memory: arbitrates remote acquire/release
// requests, answers each with a registered tagged response, and force-releases stale leases.
module bsg_manycore_lock_table #(
  parameter int addr_width_p   = 32,
  parameter int x_cord_width_p = 4,
  parameter int y_cord_width_p = 4,
  parameter int els_p          = 4,
  parameter int lease_cycles_p = 1024,
  localparam int held_width_lp = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic                      v_i,
  output logic                      yumi_o,
  input  logic                      rl_i,
  input  logic [addr_width_p-1:0]   addr_i,
  input  logic [x_cord_width_p-1:0] x_cord_i,
  input  logic [y_cord_width_p-1:0] y_cord_i,
  output logic                      resp_v_o,
  input  logic                      resp_ready_i,
  output logic                      resp_success_o,
  output logic                      resp_full_o,
  output logic [x_cord_width_p-1:0] resp_x_cord_o,
  output logic [y_cord_width_p-1:0] resp_y_cord_o,
  output logic                      expired_v_o,
  output logic [held_width_lp-1:0]  locks_held_o
);

  localparam int idx_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int lc_width_lp  = (lease_cycles_p > 0) ? $clog2(lease_cycles_p + 1) : 1;
  localparam bit lease_en_lp  = (lease_cycles_p > 0);
  localparam logic [lc_width_lp-1:0] lease_last_lp = lc_width_lp'(lease_cycles_p - 1);

  function automatic logic [held_width_lp-1:0] popcount(input logic [els_p-1:0] vec);
    logic [held_width_lp-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < els_p; i++) begin
      cnt = cnt + held_width_lp'(vec[i]);
    end
    return cnt;
  endfunction

  logic [els_p-1:0]          valid_q, valid_d;
  logic [addr_width_p-1:0]   addr_q [els_p];
  logic [addr_width_p-1:0]   addr_d [els_p];
  logic [x_cord_width_p-1:0] x_q [els_p];
  logic [x_cord_width_p-1:0] x_d [els_p];
  logic [y_cord_width_p-1:0] y_q [els_p];
  logic [y_cord_width_p-1:0] y_d [els_p];
  logic [lc_width_lp-1:0]    cnt_q [els_p];
  logic [lc_width_lp-1:0]    cnt_d [els_p];

  logic                      resp_v_q, resp_v_d;
  logic                      resp_success_q, resp_success_d;
  logic                      resp_full_q, resp_full_d;
  logic [x_cord_width_p-1:0] resp_x_q, resp_x_d;
  logic [y_cord_width_p-1:0] resp_y_q, resp_y_d;
  logic                      expired_q, expired_d;
  logic [held_width_lp-1:0]  held_q, held_d;

  logic                      acq_hit_s;
  logic                      rel_hit_s;
  logic [idx_width_lp-1:0]   rel_idx_s;
  logic                      free_found_s;
  logic [idx_width_lp-1:0]   free_idx_s;
  logic [els_p-1:0]          expire_s;
  logic [els_p-1:0]          rel_clr_s;

  assign yumi_o = v_i & (~resp_v_q | resp_ready_i);

  // Table lookup on pre-edge state; descending scan leaves the lowest free index.
  always_comb begin
    acq_hit_s    = 1'b0;
    rel_hit_s    = 1'b0;
    rel_idx_s    = '0;
    free_found_s = 1'b0;
    free_idx_s   = '0;
    expire_s     = '0;
    for (int i = els_p - 1; i >= 0; i--) begin
      acq_hit_s   = acq_hit_s | (valid_q[i] & (addr_q[i] == addr_i));
      expire_s[i] = lease_en_lp & valid_q[i] & (cnt_q[i] == lease_last_lp);
      if (valid_q[i] && (addr_q[i] == addr_i) && (x_q[i] == x_cord_i) && (y_q[i] == y_cord_i)) begin
        rel_hit_s = 1'b1;
        rel_idx_s = idx_width_lp'(i);
      end else begin
        rel_idx_s = rel_idx_s;
      end
      if (!valid_q[i]) begin
        free_found_s = 1'b1;
        free_idx_s   = idx_width_lp'(i);
      end else begin
        free_idx_s   = free_idx_s;
      end
    end
  end

  // Next table state, response and status; a release beats a same-edge expiry.
  always_comb begin
    valid_d        = valid_q & ~expire_s;
    addr_d         = addr_q;
    x_d            = x_q;
    y_d            = y_q;
    rel_clr_s      = '0;
    resp_v_d       = resp_v_q & ~resp_ready_i;
    resp_success_d = resp_success_q;
    resp_full_d    = resp_full_q;
    resp_x_d       = resp_x_q;
    resp_y_d       = resp_y_q;
    for (int i = 0; i < els_p; i++) begin
      if (lease_en_lp && valid_q[i] && !expire_s[i]) begin
        cnt_d[i] = cnt_q[i] + lc_width_lp'(1);
      end else begin
        cnt_d[i] = '0;
      end
    end

    if (yumi_o) begin
      resp_v_d = 1'b1;
      resp_x_d = x_cord_i;
      resp_y_d = y_cord_i;
      if (rl_i) begin
        resp_success_d = rel_hit_s;
        resp_full_d    = 1'b0;
        if (rel_hit_s) begin
          valid_d[rel_idx_s]   = 1'b0;
          rel_clr_s[rel_idx_s] = 1'b1;
        end else begin
          rel_clr_s = '0;
        end
      end else begin
        resp_success_d = ~acq_hit_s & free_found_s;
        resp_full_d    = ~acq_hit_s & ~free_found_s;
        if (!acq_hit_s && free_found_s) begin
          valid_d[free_idx_s] = 1'b1;
          addr_d[free_idx_s]  = addr_i;
          x_d[free_idx_s]     = x_cord_i;
          y_d[free_idx_s]     = y_cord_i;
          cnt_d[free_idx_s]   = '0;
        end else begin
          valid_d = valid_d;
        end
      end
    end else begin
      resp_v_d = resp_v_d;
    end

    expired_d = |(expire_s & ~rel_clr_s);
    held_d    = popcount(valid_d);
  end

  // State registers; reset frees every lock and drops any pending response.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q        <= '0;
      resp_v_q       <= 1'b0;
      resp_success_q <= 1'b0;
      resp_full_q    <= 1'b0;
      resp_x_q       <= '0;
      resp_y_q       <= '0;
      expired_q      <= 1'b0;
      held_q         <= '0;
      for (int i = 0; i < els_p; i++) begin
        addr_q[i] <= '0;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      valid_q        <= valid_d;
      resp_v_q       <= resp_v_d;
      resp_success_q <= resp_success_d;
      resp_full_q    <= resp_full_d;
      resp_x_q       <= resp_x_d;
      resp_y_q       <= resp_y_d;
      expired_q      <= expired_d;
      held_q         <= held_d;
      for (int i = 0; i < els_p; i++) begin
        addr_q[i] <= addr_d[i];
        x_q[i]    <= x_d[i];
        y_q[i]    <= y_d[i];
        cnt_q[i]  <= cnt_d[i];
      end
    end
  end

  assign resp_v_o       = resp_v_q;
  assign resp_success_o = resp_success_q;
  assign resp_full_o    = resp_full_q;
  assign resp_x_cord_o  = resp_x_q;
  assign resp_y_cord_o  = resp_y_q;
  assign expired_v_o    = expired_q;
  assign locks_held_o   = held_q;

endmodule

// File: tb/tb_bsg_manycore_lock_table.sv
// Directed bench: dut_a (long lease) covers table/handshake/reset behaviour,
// dut_b (lease 8) covers forced release; both share the request inputs.
module tb_bsg_manycore_lock_table;

  logic        clk;
  logic        reset_n;
  logic        v;
  logic        rl;
  logic [31:0] addr;
  logic [3:0]  x;
  logic [3:0]  y;
  logic        resp_ready;

  logic        a_yumi, a_resp_v, a_success, a_full, a_expired;
  logic [3:0]  a_rx, a_ry;
  logic [2:0]  a_locks;
  logic        b_yumi, b_resp_v, b_success, b_full, b_expired;
  logic [3:0]  b_rx, b_ry;
  logic [2:0]  b_locks;

  int checks = 0;
  int errors = 0;

  bsg_manycore_lock_table #(.addr_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
                            .els_p(4), .lease_cycles_p(1024)) dut_a (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_o(a_yumi), .rl_i(rl), .addr_i(addr),
    .x_cord_i(x), .y_cord_i(y), .resp_v_o(a_resp_v), .resp_ready_i(resp_ready),
    .resp_success_o(a_success), .resp_full_o(a_full), .resp_x_cord_o(a_rx),
    .resp_y_cord_o(a_ry), .expired_v_o(a_expired), .locks_held_o(a_locks));

  bsg_manycore_lock_table #(.addr_width_p(32), .x_cord_width_p(4), .y_cord_width_p(4),
                            .els_p(4), .lease_cycles_p(8)) dut_b (
    .clk_i(clk), .reset_n_i(reset_n), .v_i(v), .yumi_o(b_yumi), .rl_i(rl), .addr_i(addr),
    .x_cord_i(x), .y_cord_i(y), .resp_v_o(b_resp_v), .resp_ready_i(resp_ready),
    .resp_success_o(b_success), .resp_full_o(b_full), .resp_x_cord_o(b_rx),
    .resp_y_cord_o(b_ry), .expired_v_o(b_expired), .locks_held_o(b_locks));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One request, accepted at the next edge; returns at the negedge where its response is visible.
  task automatic do_req(input logic r, input logic [31:0] a, input logic [3:0] xx,
                        input logic [3:0] yy, input string tag);
    @(posedge clk); #1;
    v = 1'b1; rl = r; addr = a; x = xx; y = yy;
    @(negedge clk);
    check({tag, ".yumi"}, {31'd0, a_yumi}, 32'd1);
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; v = 1'b0; rl = 1'b0; addr = 32'd0; x = 4'd0; y = 4'd0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst.resp_v", {31'd0, a_resp_v}, 32'd0);
    check("rst.locks", {29'd0, a_locks}, 32'd0);
    check("rst.expired", {31'd0, a_expired}, 32'd0);
    check("rst.success", {31'd0, a_success}, 32'd0);
    check("rst.rx", {28'd0, a_rx}, 32'd0);

    do_req(1'b0, 32'h40, 4'd1, 4'd2, "acq40");
    check("acq40.resp_v", {31'd0, a_resp_v}, 32'd1);
    check("acq40.success", {31'd0, a_success}, 32'd1);
    check("acq40.full", {31'd0, a_full}, 32'd0);
    check("acq40.rx", {28'd0, a_rx}, 32'd1);
    check("acq40.ry", {28'd0, a_ry}, 32'd2);
    check("acq40.locks", {29'd0, a_locks}, 32'd1);

    do_req(1'b0, 32'h40, 4'd3, 4'd0, "reacq40");
    check("reacq40.success", {31'd0, a_success}, 32'd0);
    check("reacq40.full", {31'd0, a_full}, 32'd0);
    check("reacq40.rx", {28'd0, a_rx}, 32'd3);
    do_req(1'b1, 32'h40, 4'd3, 4'd0, "badrel40");
    check("badrel40.success", {31'd0, a_success}, 32'd0);
    check("badrel40.locks", {29'd0, a_locks}, 32'd1);
    do_req(1'b1, 32'h40, 4'd1, 4'd2, "rel40");
    check("rel40.success", {31'd0, a_success}, 32'd1);
    check("rel40.locks", {29'd0, a_locks}, 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 32'h10 + 32'(i), 4'd1, 4'd1, "fill");
      check("fill.success", {31'd0, a_success}, 32'd1);
      check("fill.locks", {29'd0, a_locks}, 32'(i + 1));
    end
    do_req(1'b0, 32'h14, 4'd1, 4'd1, "acq14full");
    check("acq14full.success", {31'd0, a_success}, 32'd0);
    check("acq14full.full", {31'd0, a_full}, 32'd1);
    check("acq14full.locks", {29'd0, a_locks}, 32'd4);
    do_req(1'b1, 32'h11, 4'd1, 4'd1, "rel11");
    check("rel11.success", {31'd0, a_success}, 32'd1);
    check("rel11.locks", {29'd0, a_locks}, 32'd3);
    do_req(1'b0, 32'h14, 4'd1, 4'd1, "acq14");
    check("acq14.success", {31'd0, a_success}, 32'd1);
    check("acq14.full", {31'd0, a_full}, 32'd0);
    check("acq14.locks", {29'd0, a_locks}, 32'd4);
    check("acq14.entry1", dut_a.addr_q[1], 32'h14);

    // Backpressure: hold the response with ready low while a second request waits.
    @(posedge clk); #1;
    resp_ready = 1'b0; v = 1'b1; rl = 1'b0; addr = 32'h20; x = 4'd2; y = 4'd2;
    @(negedge clk);
    check("bp.first_yumi", {31'd0, a_yumi}, 32'd1);
    @(posedge clk); #1;
    addr = 32'h21; x = 4'd3; y = 4'd3;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp.yumi", {31'd0, a_yumi}, 32'd0);
      check("bp.resp_v", {31'd0, a_resp_v}, 32'd1);
      check("bp.rx", {28'd0, a_rx}, 32'd2);
      check("bp.full", {31'd0, a_full}, 32'd1);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp.ready_yumi", {31'd0, a_yumi}, 32'd1);
    check("bp.old_rx", {28'd0, a_rx}, 32'd2);
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    check("bp.new_resp_v", {31'd0, a_resp_v}, 32'd1);
    check("bp.new_rx", {28'd0, a_rx}, 32'd3);
    check("bp.new_full", {31'd0, a_full}, 32'd1);

    // Async reset while a response is pending and three locks are held.
    do_req(1'b1, 32'h10, 4'd1, 4'd1, "rel10");
    check("rel10.locks", {29'd0, a_locks}, 32'd3);
    @(posedge clk); #1;
    resp_ready = 1'b0; v = 1'b1; rl = 1'b1; addr = 32'h99; x = 4'd1; y = 4'd1;
    @(posedge clk); #1;
    v = 1'b0;
    @(negedge clk);
    check("arst.pre_resp_v", {31'd0, a_resp_v}, 32'd1);
    check("arst.pre_locks", {29'd0, a_locks}, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst.resp_v", {31'd0, a_resp_v}, 32'd0);
    check("arst.locks", {29'd0, a_locks}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; resp_ready = 1'b1;
    do_req(1'b0, 32'h12, 4'd5, 4'd5, "postrst");
    check("postrst.success", {31'd0, a_success}, 32'd1);
    check("postrst.locks", {29'd0, a_locks}, 32'd1);

    // Lease expiry on dut_b (lease 8) from a clean table.
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    do_req(1'b0, 32'h40, 4'd1, 4'd2, "lease");
    check("lease.success", {31'd0, b_success}, 32'd1);
    check("lease.locks0", {29'd0, b_locks}, 32'd1);
    for (int k = 1; k < 8; k++) begin
      @(posedge clk); @(negedge clk);
      check("lease.held", {29'd0, b_locks}, 32'd1);
      check("lease.noexp", {31'd0, b_expired}, 32'd0);
    end
    @(posedge clk); @(negedge clk);
    check("lease.expired", {31'd0, b_expired}, 32'd1);
    check("lease.freed", {29'd0, b_locks}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("lease.pulse_end", {31'd0, b_expired}, 32'd0);

    do_req(1'b0, 32'h40, 4'd1, 4'd2, "lease2");
    check("lease2.success", {31'd0, b_success}, 32'd1);
    for (int k = 1; k < 7; k++) begin
      @(posedge clk); @(negedge clk);
    end
    do_req(1'b1, 32'h40, 4'd1, 4'd2, "termrel");
    check("termrel.success", {31'd0, b_success}, 32'd1);
    check("termrel.locks", {29'd0, b_locks}, 32'd0);
    check("termrel.noexp", {31'd0, b_expired}, 32'd0);
    @(posedge clk); @(negedge clk);
    check("termrel.noexp2", {31'd0, b_expired}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
